// File: rtl/rv32i_types.sv
// Shared RV32I encodings, datapath mux selects and controller state for the multicycle core.
package rv32i_types;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [2:0] {
      alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and
   } alu_ops;

   typedef enum logic [2:0] {
      beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
   } branch_funct3_t;

   typedef enum logic [2:0] {lb = 3'b000, lh = 3'b001, lw = 3'b010, lbu = 3'b100, lhu = 3'b101} load_funct3_t;
   typedef enum logic [2:0] {sb = 3'b000, sh = 3'b001, sw = 3'b010} store_funct3_t;
   typedef enum logic [2:0] {add = 3'b000, sll, slt, sltu, axor, sr, aor, aand} arith_funct3_t;

   typedef enum logic [1:0] {pcmux_pc_plus4, pcmux_alu_out, pcmux_alu_mod2} pcmux_sel_t;
   typedef enum logic {marmux_pc_out, marmux_alu_out} marmux_sel_t;
   typedef enum logic {cmpmux_rs2_out, cmpmux_i_imm} cmpmux_sel_t;
   typedef enum logic {alumux1_rs1_out, alumux1_pc_out} alumux1_sel_t;
   typedef enum logic [2:0] {
      alumux2_i_imm, alumux2_u_imm, alumux2_b_imm, alumux2_s_imm, alumux2_j_imm, alumux2_rs2_out
   } alumux2_sel_t;
   typedef enum logic [3:0] {
      rfmux_alu_out, rfmux_br_en, rfmux_u_imm, rfmux_lw, rfmux_pc_plus4,
      rfmux_lb, rfmux_lbu, rfmux_lh, rfmux_lhu
   } regfilemux_sel_t;

   typedef enum logic [4:0] {
      FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC, BR,
      ADDR, LD1, LD2, ST1, ST2, JAL, JALR, TRAP
   } state_t;

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         sh:      return 4'b0011 << off;
         sb:      return 4'b0001 << off;
         default: return 4'b1111;
      endcase
   endfunction

   // funct3[1:0] carries the access size for both loads and stores
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b10:   return off != 2'b00;
         2'b01:   return off[0];
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_control_decode.sv
// Combinational decode of the IR fields into the execute state and ALU/compare ops.
module cpu_control_decode
   import rv32i_types::*;
(
   input  logic [6:0]     opcode,
   input  logic [2:0]     funct3,
   input  logic [6:0]     funct7,
   output state_t         exec_state,
   output alu_ops         aluop,
   output branch_funct3_t cmpop
);

   logic unused_f7;
   assign unused_f7 = ^{funct7[6], funct7[4:0]};

   always_comb begin
      exec_state = TRAP;
      aluop      = alu_add;
      cmpop      = beq;
      case (opcode)
         op_lui:   exec_state = LUI;
         op_auipc: exec_state = AUIPC;
         op_jal:   exec_state = JAL;
         op_jalr:  exec_state = JALR;
         op_load,
         op_store: exec_state = ADDR;
         op_br: begin
            exec_state = BR;
            cmpop      = branch_funct3_t'(funct3);
         end
         op_imm, op_reg: begin
            exec_state = (opcode == op_imm) ? IMM : REG;
            aluop      = alu_ops'(funct3);
            // funct7 is immediate bits for most op_imm forms; only the shift uses bit 5
            if (funct7[5] && funct3 == sr)
               aluop = alu_sra;
            else if (funct7[5] && funct3 == add && opcode == op_reg)
               aluop = alu_sub;
            if (funct3 == slt)  cmpop = blt;
            if (funct3 == sltu) cmpop = bltu;
         end
         default: exec_state = TRAP;
      endcase
   end

endmodule

// File: rtl/cpu_control.sv
// Multicycle RV32I control FSM: fetch, decode, execute and memory handshake, with sticky trap.
module cpu_control
   import rv32i_types::*;
#(
   parameter int unsigned MEM_TIMEOUT = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic            br_en,
   input  logic [1:0]      mem_offset,
   input  logic            mem_resp,
   output alu_ops          aluop,
   output branch_funct3_t  cmpop,
   output cmpmux_sel_t     cmpmux_sel,
   output pcmux_sel_t      pcmux_sel,
   output marmux_sel_t     marmux_sel,
   output alumux1_sel_t    alumux1_sel,
   output alumux2_sel_t    alumux2_sel,
   output regfilemux_sel_t regfilemux_sel,
   output logic            load_ir,
   output logic            load_mar,
   output logic            load_pc,
   output logic            load_regfile,
   output logic            load_mdr,
   output logic            load_data_out,
   output logic            mem_read,
   output logic            mem_write,
   output logic [3:0]      mem_byte_enable,
   output logic            trap
);

   state_t         state_q, state_d, dec_state;
   logic [1:0]     offset_q, offset_d;
   logic           trap_q, trap_d;
   logic [31:0]    wait_q, wait_d;
   logic           mem_state, timed_out;
   alu_ops         dec_aluop;
   branch_funct3_t dec_cmpop;

   cpu_control_decode u_dec (
      .opcode    (opcode),
      .funct3    (funct3),
      .funct7    (funct7),
      .exec_state(dec_state),
      .aluop     (dec_aluop),
      .cmpop     (dec_cmpop)
   );

   assign trap      = trap_q;
   assign mem_state = (state_q == FETCH2) || (state_q == LD1) || (state_q == ST1);
   assign timed_out = (MEM_TIMEOUT != 0) && !mem_resp && (wait_q == MEM_TIMEOUT - 1);

   always_comb begin
      state_d         = state_q;
      offset_d        = offset_q;
      load_ir         = 1'b0;
      load_mar        = 1'b0;
      load_pc         = 1'b0;
      load_regfile    = 1'b0;
      load_mdr        = 1'b0;
      load_data_out   = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = 4'b1111;
      aluop           = alu_add;
      cmpop           = beq;
      pcmux_sel       = pcmux_pc_plus4;
      marmux_sel      = marmux_pc_out;
      cmpmux_sel      = cmpmux_rs2_out;
      alumux1_sel     = alumux1_rs1_out;
      alumux2_sel     = alumux2_i_imm;
      regfilemux_sel  = rfmux_alu_out;
      // Outputs are forced idle while reset is held so an abort takes effect immediately
      if (!rst) begin
         case (state_q)
            FETCH1: begin
               load_mar = 1'b1;
               state_d  = FETCH2;
            end
            FETCH2: begin
               mem_read = 1'b1;
               if (mem_resp) begin
                  load_mdr = 1'b1;
                  state_d  = FETCH3;
               end else if (timed_out) state_d = TRAP;
            end
            FETCH3: begin
               load_ir = 1'b1;
               state_d = DECODE;
            end
            DECODE: state_d = dec_state;
            IMM, REG: begin
               aluop        = dec_aluop;
               cmpop        = dec_cmpop;
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               if (state_q == REG) alumux2_sel = alumux2_rs2_out;
               if (funct3 == slt || funct3 == sltu) begin
                  regfilemux_sel = rfmux_br_en;
                  if (state_q == IMM) cmpmux_sel = cmpmux_i_imm;
               end
               state_d = FETCH1;
            end
            LUI: begin
               regfilemux_sel = rfmux_u_imm;
               load_regfile   = 1'b1;
               load_pc        = 1'b1;
               state_d        = FETCH1;
            end
            AUIPC: begin
               alumux1_sel  = alumux1_pc_out;
               alumux2_sel  = alumux2_u_imm;
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               state_d      = FETCH1;
            end
            BR: begin
               alumux1_sel = alumux1_pc_out;
               alumux2_sel = alumux2_b_imm;
               cmpop       = dec_cmpop;
               load_pc     = 1'b1;
               pcmux_sel   = br_en ? pcmux_alu_out : pcmux_pc_plus4;
               state_d     = FETCH1;
            end
            JAL, JALR: begin
               regfilemux_sel = rfmux_pc_plus4;
               load_regfile   = 1'b1;
               load_pc        = 1'b1;
               if (state_q == JAL) begin
                  alumux1_sel = alumux1_pc_out;
                  alumux2_sel = alumux2_j_imm;
                  pcmux_sel   = pcmux_alu_out;
               end else pcmux_sel = pcmux_alu_mod2;
               state_d = FETCH1;
            end
            ADDR: begin
               marmux_sel = marmux_alu_out;
               load_mar   = 1'b1;
               offset_d   = mem_offset;
               if (opcode == op_store) begin
                  alumux2_sel   = alumux2_s_imm;
                  load_data_out = 1'b1;
                  state_d       = ST1;
               end else state_d = LD1;
               if (misaligned(funct3, mem_offset)) state_d = TRAP;
            end
            LD1: begin
               mem_read = 1'b1;
               if (mem_resp) begin
                  load_mdr = 1'b1;
                  state_d  = LD2;
               end else if (timed_out) state_d = TRAP;
            end
            LD2: begin
               case (funct3)
                  lb:      regfilemux_sel = rfmux_lb;
                  lh:      regfilemux_sel = rfmux_lh;
                  lbu:     regfilemux_sel = rfmux_lbu;
                  lhu:     regfilemux_sel = rfmux_lhu;
                  default: regfilemux_sel = rfmux_lw;
               endcase
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               state_d      = FETCH1;
            end
            ST1: begin
               mem_write       = 1'b1;
               mem_byte_enable = store_be(funct3, offset_q);
               if (mem_resp) state_d = ST2;
               else if (timed_out) state_d = TRAP;
            end
            ST2: begin
               load_pc = 1'b1;
               state_d = FETCH1;
            end
            default: state_d = TRAP;
         endcase
      end
   end

   always_comb begin
      trap_d = trap_q | (state_d == TRAP);
      wait_d = (mem_state && state_d == state_q) ? wait_q + 32'd1 : 32'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= FETCH1;
         offset_q <= 2'b00;
         trap_q   <= 1'b0;
         wait_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
         trap_q   <= trap_d;
         wait_q   <= wait_d;
      end
   end

endmodule

// File: tb/tb_cpu_control.sv
// Random and directed instruction streams checked cycle by cycle against a per-instruction trace model.
module tb_cpu_control;
   import rv32i_types::*;

   localparam int TMO = 4;

   typedef struct packed {
      logic       ld_ir, ld_mar, ld_pc, ld_rf, ld_mdr, ld_do;
      logic       rd, wr;
      logic [3:0] be;
      logic [2:0] aluop, cmpop;
      logic [1:0] pcmux;
      logic       marmux, cmpmux, alu1;
      logic [2:0] alu2;
      logic [3:0] rfmux;
      logic       trap;
   } ctl_t;

   logic clk = 1'b0;
   logic rst, br_en, mem_resp;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [1:0] mem_offset;
   alu_ops          aluop;
   branch_funct3_t  cmpop;
   cmpmux_sel_t     cmpmux_sel;
   pcmux_sel_t      pcmux_sel;
   marmux_sel_t     marmux_sel;
   alumux1_sel_t    alumux1_sel;
   alumux2_sel_t    alumux2_sel;
   regfilemux_sel_t regfilemux_sel;
   logic load_ir, load_mar, load_pc, load_regfile, load_mdr, load_data_out;
   logic mem_read, mem_write, trap;
   logic [3:0] mem_byte_enable;
   ctl_t obs;

   int n_chk = 0, n_err = 0;
   ctl_t  eq[$];
   bit    rq[$];
   string tq[$];

   always #5 clk = ~clk;

   cpu_control #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .br_en(br_en), .mem_offset(mem_offset), .mem_resp(mem_resp),
      .aluop(aluop), .cmpop(cmpop), .cmpmux_sel(cmpmux_sel), .pcmux_sel(pcmux_sel),
      .marmux_sel(marmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
      .regfilemux_sel(regfilemux_sel), .load_ir(load_ir), .load_mar(load_mar),
      .load_pc(load_pc), .load_regfile(load_regfile), .load_mdr(load_mdr),
      .load_data_out(load_data_out), .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .trap(trap)
   );

   assign obs = {load_ir, load_mar, load_pc, load_regfile, load_mdr, load_data_out,
                 mem_read, mem_write, mem_byte_enable, aluop, cmpop, pcmux_sel, marmux_sel,
                 cmpmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, trap};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h want %h", tag, $time, got, exp);
      end
   endtask

   function automatic ctl_t dflt();
      ctl_t c = '0;
      c.be = 4'hf;
      return c;
   endfunction

   function automatic bit nz();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input string t, input bit r, input ctl_t c);
      tq.push_back(t);
      rq.push_back(r);
      eq.push_back(c);
   endtask

   // A memory wait of d idle cycles then a resp cycle; d >= TMO never answers and times out
   task automatic mem_wait(input string t, input bit wr, input logic [3:0] be, input int d, output bit to);
      ctl_t c = dflt();
      if (wr) begin c.wr = 1'b1; c.be = be; end
      else c.rd = 1'b1;
      to = (d >= TMO);
      for (int i = 0; i < (to ? TMO : d); i++) push(t, 1'b0, c);
      if (!to) begin
         if (!wr) c.ld_mdr = 1'b1;
         push(t, 1'b1, c);
      end
   endtask

   task automatic model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input bit br, input logic [1:0] off, input int fd, input int md,
                        output bit trapped);
      ctl_t c;
      bit   to;
      int   nb;
      trapped = 1'b0;
      c = dflt(); c.ld_mar = 1'b1;
      push("FETCH1", nz(), c);
      mem_wait("FETCH2", 1'b0, 4'hf, fd, to);
      trapped = to;
      if (!to) begin
         c = dflt(); c.ld_ir = 1'b1;
         push("FETCH3", nz(), c);
         push("DECODE", nz(), dflt());
         c = dflt();
         case (opc)
            op_imm, op_reg: begin
               c.ld_rf = 1'b1; c.ld_pc = 1'b1;
               c.aluop = f3;
               if (f3 == 3'b101 && f7[5]) c.aluop = alu_sra;
               if (opc == op_reg && f3 == 3'b000 && f7[5]) c.aluop = alu_sub;
               if (opc == op_reg) c.alu2 = alumux2_rs2_out;
               if (f3 == 3'b010 || f3 == 3'b011) begin
                  c.rfmux = rfmux_br_en;
                  c.cmpop = f3[0] ? bltu : blt;
                  if (opc == op_imm) c.cmpmux = cmpmux_i_imm;
               end
               push("ALU", nz(), c);
            end
            op_lui: begin
               c.rfmux = rfmux_u_imm; c.ld_rf = 1'b1; c.ld_pc = 1'b1;
               push("LUI", nz(), c);
            end
            op_auipc: begin
               c.alu1 = alumux1_pc_out; c.alu2 = alumux2_u_imm; c.ld_rf = 1'b1; c.ld_pc = 1'b1;
               push("AUIPC", nz(), c);
            end
            op_br: begin
               c.alu1 = alumux1_pc_out; c.alu2 = alumux2_b_imm; c.ld_pc = 1'b1; c.cmpop = f3;
               c.pcmux = br ? pcmux_alu_out : pcmux_pc_plus4;
               push("BR", nz(), c);
            end
            op_jal, op_jalr: begin
               c.rfmux = rfmux_pc_plus4; c.ld_rf = 1'b1; c.ld_pc = 1'b1;
               if (opc == op_jal) begin
                  c.alu1 = alumux1_pc_out; c.alu2 = alumux2_j_imm; c.pcmux = pcmux_alu_out;
               end else c.pcmux = pcmux_alu_mod2;
               push("JUMP", nz(), c);
            end
            op_load, op_store: begin
               c.ld_mar = 1'b1; c.marmux = marmux_alu_out;
               c.alu2  = (opc == op_store) ? alumux2_s_imm : alumux2_i_imm;
               c.ld_do = (opc == op_store);
               push("ADDR", nz(), c);
               nb = (f3[1:0] == 2'b10) ? 4 : (f3[1:0] == 2'b01) ? 2 : 1;
               if (int'(off) % nb != 0) trapped = 1'b1;
               else if (opc == op_load) begin
                  mem_wait("LD1", 1'b0, 4'hf, md, to);
                  trapped = to;
                  if (!to) begin
                     c = dflt(); c.ld_rf = 1'b1; c.ld_pc = 1'b1;
                     case (f3)
                        3'b000:  c.rfmux = rfmux_lb;
                        3'b001:  c.rfmux = rfmux_lh;
                        3'b100:  c.rfmux = rfmux_lbu;
                        3'b101:  c.rfmux = rfmux_lhu;
                        default: c.rfmux = rfmux_lw;
                     endcase
                     push("LD2", nz(), c);
                  end
               end else begin
                  mem_wait("ST1", 1'b1, (nb == 4) ? 4'hf : (nb == 2) ? (4'h3 << off) : (4'h1 << off), md, to);
                  trapped = to;
                  if (!to) begin
                     c = dflt(); c.ld_pc = 1'b1;
                     push("ST2", nz(), c);
                  end
               end
            end
            default: trapped = 1'b1;
         endcase
      end
      if (trapped) begin
         c = dflt(); c.trap = 1'b1;
         for (int i = 0; i < 3; i++) push("TRAP", nz(), c);
      end
   endtask

   task automatic run_q();
      for (int i = 0; i < eq.size(); i++) begin
         mem_resp = rq[i];
         // the latched offset must be used in ST1, not the live ALU bits
         if (tq[i] == "ST1") mem_offset = 2'($urandom);
         @(negedge clk);
         chk(tq[i], {1'b0, obs}, {1'b0, eq[i]});
         @(posedge clk); #1;
      end
      mem_resp = 1'b0;
      eq.delete(); rq.delete(); tq.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1 chk("rst_defaults", {1'b0, obs}, {1'b0, dflt()});
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                            input bit br, input logic [1:0] off, input int fd, input int md);
      bit tr;
      opcode = opc; funct3 = f3; funct7 = f7; br_en = br; mem_offset = off;
      model(opc, f3, f7, br, off, fd, md, tr);
      run_q();
      if (tr) do_reset();
   endtask

   function automatic bit legal(input logic [6:0] o);
      return o inside {op_lui, op_auipc, op_jal, op_jalr, op_br, op_load, op_store, op_imm, op_reg};
   endfunction

   logic [6:0] ops [9] = '{op_lui, op_auipc, op_jal, op_jalr, op_br, op_load, op_store, op_imm, op_reg};
   logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

   initial begin
      ctl_t f1;
      logic [6:0] o;
      logic [2:0] f;
      f1 = dflt(); f1.ld_mar = 1'b1;
      rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; br_en = 1'b0; mem_resp = 1'b0; mem_offset = '0;
      @(posedge clk); #1;
      chk("reset", {1'b0, obs}, {1'b0, dflt()});
      @(posedge clk); #1;
      rst = 1'b0;

      run_instr(op_imm,   3'b000, 7'h00, 1'b0, 2'd0, 0, 0);   // addi
      run_instr(op_imm,   3'b000, 7'h20, 1'b0, 2'd0, 1, 0);   // addi with imm bit 10 set
      run_instr(op_br,    3'b000, 7'h00, 1'b1, 2'd0, 0, 0);   // beq taken
      run_instr(op_br,    3'b000, 7'h00, 1'b0, 2'd0, 0, 0);   // beq not taken
      run_instr(op_load,  3'b010, 7'h00, 1'b0, 2'd0, 0, 3);   // lw, slow memory
      run_instr(op_store, 3'b000, 7'h00, 1'b0, 2'd2, 0, 0);   // sb off 2
      run_instr(op_store, 3'b001, 7'h00, 1'b0, 2'd2, 0, 1);   // sh off 2
      run_instr(op_store, 3'b001, 7'h00, 1'b0, 2'd1, 0, 0);   // sh misaligned
      run_instr(op_imm,   3'b000, 7'h00, 1'b0, 2'd0, TMO, 0); // fetch timeout
      run_instr(7'h00,    3'b000, 7'h00, 1'b0, 2'd0, 0, 0);   // illegal opcode

      // abort in the middle of an instruction fetch
      opcode = op_imm; mem_resp = 1'b0;
      @(negedge clk); chk("pre_abort_f1", {1'b0, obs}, {1'b0, f1});
      @(posedge clk); #1;
      @(negedge clk); chk("f2_read", {31'b0, mem_read}, 32'd1);
      #1 rst = 1'b1;
      #1 chk("abort_async", {1'b0, obs}, {1'b0, dflt()});
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); chk("post_abort_f1", {1'b0, obs}, {1'b0, f1});
      @(posedge clk); #1;
      do_reset();

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 11) == 0) begin
            do o = 7'($urandom); while (legal(o));
         end else o = ops[$urandom_range(0, 8)];
         if (o == op_load) f = ld_f3[$urandom_range(0, 4)];
         else if (o == op_store) f = 3'($urandom_range(0, 2));
         else f = 3'($urandom);
         run_instr(o, f, 7'($urandom), 1'($urandom), 2'($urandom),
                   ($urandom_range(0, 15) == 0) ? TMO : $urandom_range(0, 3),
                   ($urandom_range(0, 11) == 0) ? TMO : $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
